// File: rtl/data_memory_ctrl.sv
// Data memory controller: byte/half/word loads and stores, hardware RAM clear after reset,
// sticky fault capture, peripheral region pass-through and selectable read latency.
module data_memory_ctrl #(
    parameter int          ADDR_BITS    = 7,
    parameter int          READ_LATENCY = 0,
    parameter logic [31:0] INIT_VALUE   = 32'h00000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Address,
    input  logic [31:0]          Write_data,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [1:0]           Size,
    input  logic                 Unsigned,
    output logic [31:0]          Read_data,
    output logic                 busy,
    output logic                 fault,
    output logic [31:0]          fault_addr,
    input  logic                 fault_clr,
    output logic                 periph_rd,
    output logic                 periph_wr,
    output logic [3:0]           periph_be,
    output logic [31:0]          periph_wdata,
    input  logic [31:0]          periph_rdata,
    input  logic [ADDR_BITS-1:0] showaddr,
    output logic [31:0]          ramshowdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clrCnt_q, clrCnt_d;
    logic                   fault_q, fault_d;
    logic [31:0]            faultAddr_q, faultAddr_d;

    logic [31:0]            mem [DEPTH];

    logic [ADDR_BITS-1:0]   wordIdx;
    logic                   inRun;
    logic                   isPeriph;
    logic                   isRam;
    logic                   misaligned;
    logic                   access;
    logic                   faultNow;
    logic                   accessOk;
    logic                   ramWe;
    logic                   loadValid;
    logic [3:0]             laneBe;
    logic [31:0]            laneWdata;
    logic [31:0]            srcWord;
    logic [7:0]             selByte;
    logic [15:0]            selHalf;
    logic [31:0]            extData;
    logic [31:0]            loadData;
    logic                   unusedAddrBit;

    assign unusedAddrBit = Address[31];

    assign wordIdx  = Address[ADDR_BITS+1:2];
    assign inRun    = (state_q == ST_RUN);
    assign isPeriph = Address[30];
    assign isRam    = !Address[30] && (Address[29:ADDR_BITS+2] == '0);

    always_comb begin
        misaligned = 1'b0;
        case (Size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = Address[0];
            2'b10:   misaligned = (Address[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Faults are only recognised once the clear sequence has finished.
    assign access    = inRun && (MemRead || MemWrite);
    assign faultNow  = access && (misaligned || !(isPeriph || isRam));
    assign accessOk  = access && !faultNow;
    assign ramWe     = accessOk && MemWrite && isRam;
    assign loadValid = accessOk && MemRead;

    assign periph_rd = accessOk && MemRead && isPeriph;
    assign periph_wr = accessOk && MemWrite && isPeriph;

    always_comb begin
        laneBe    = 4'b0000;
        laneWdata = Write_data;
        case (Size)
            2'b00: begin
                laneBe    = 4'b0001 << Address[1:0];
                laneWdata = {4{Write_data[7:0]}};
            end
            2'b01: begin
                laneBe    = Address[1] ? 4'b1100 : 4'b0011;
                laneWdata = {2{Write_data[15:0]}};
            end
            2'b10: begin
                laneBe    = 4'b1111;
                laneWdata = Write_data;
            end
            default: begin
                laneBe    = 4'b0000;
                laneWdata = Write_data;
            end
        endcase
    end

    assign periph_be    = (periph_rd || periph_wr) ? laneBe : 4'b0000;
    assign periph_wdata = laneWdata;

    always_comb begin
        state_d     = state_q;
        clrCnt_d    = clrCnt_q;
        fault_d     = fault_q;
        faultAddr_d = faultAddr_q;
        if (state_q == ST_CLEAR) begin
            clrCnt_d = clrCnt_q + 1'b1;
            if (clrCnt_q == {ADDR_BITS{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
        // A new fault beats a coincident clear and re-captures its address.
        if (faultNow && (!fault_q || fault_clr)) begin
            fault_d     = 1'b1;
            faultAddr_d = Address;
        end else if (fault_clr && !faultNow) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clrCnt_q    <= '0;
            fault_q     <= 1'b0;
            faultAddr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            clrCnt_q    <= clrCnt_d;
            fault_q     <= fault_d;
            faultAddr_q <= faultAddr_d;
        end
    end

    assign busy       = (state_q == ST_CLEAR);
    assign fault      = fault_q;
    assign fault_addr = faultAddr_q;

    // RAM has no reset; the clear sequence initialises it instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clrCnt_q] <= INIT_VALUE;
        end else if (ramWe) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (laneBe[lane]) begin
                    mem[wordIdx][lane*8 +: 8] <= laneWdata[lane*8 +: 8];
                end
            end
        end
    end

    assign ramshowdata = mem[showaddr];

    assign srcWord = isPeriph ? periph_rdata : mem[wordIdx];
    assign selByte = srcWord[{Address[1:0], 3'b000} +: 8];
    assign selHalf = Address[1] ? srcWord[31:16] : srcWord[15:0];

    always_comb begin
        extData = srcWord;
        case (Size)
            2'b00:   extData = {{24{~Unsigned & selByte[7]}}, selByte};
            2'b01:   extData = {{16{~Unsigned & selHalf[15]}}, selHalf};
            default: extData = srcWord;
        endcase
    end

    assign loadData = loadValid ? extData : 32'h0;

    // The array is read before the edge commits a store, so loads see the old word.
    generate
        if (READ_LATENCY == 1) begin : gRegRead
            logic [31:0] readData_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    readData_q <= 32'h0;
                end else begin
                    readData_q <= loadData;
                end
            end
            assign Read_data = readData_q;
        end else begin : gCombRead
            assign Read_data = loadData;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one combinational-read and one registered-read instance
// share the same stimulus; vectors are table-driven, clear and latency cases are hand sequences.
module tb_data_memory_ctrl;

    localparam int AB = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   address;
    logic [31:0]   writeData;
    logic          memRead;
    logic          memWrite;
    logic [1:0]    size;
    logic          isUnsigned;
    logic          faultClr;
    logic [31:0]   periphRdata;
    logic [AB-1:0] showAddr;

    logic [31:0]   readData0, faultAddr0, pwdata0, ramShow0;
    logic          busy0, fault0, prd0, pwr0;
    logic [3:0]    pbe0;

    logic [31:0]   readData1, faultAddr1, unusedPwdata1, unusedRamShow1;
    logic          busy1, fault1, unusedPrd1, unusedPwr1;
    logic [3:0]    unusedPbe1;

    int testsRun = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_BITS(AB), .READ_LATENCY(0), .INIT_VALUE(32'h0)) dutComb (
        .clk(clk), .reset(reset), .Address(address), .Write_data(writeData),
        .MemRead(memRead), .MemWrite(memWrite), .Size(size), .Unsigned(isUnsigned),
        .Read_data(readData0), .busy(busy0), .fault(fault0), .fault_addr(faultAddr0),
        .fault_clr(faultClr), .periph_rd(prd0), .periph_wr(pwr0), .periph_be(pbe0),
        .periph_wdata(pwdata0), .periph_rdata(periphRdata), .showaddr(showAddr),
        .ramshowdata(ramShow0)
    );

    data_memory_ctrl #(.ADDR_BITS(AB), .READ_LATENCY(1), .INIT_VALUE(32'h0)) dutReg (
        .clk(clk), .reset(reset), .Address(address), .Write_data(writeData),
        .MemRead(memRead), .MemWrite(memWrite), .Size(size), .Unsigned(isUnsigned),
        .Read_data(readData1), .busy(busy1), .fault(fault1), .fault_addr(faultAddr1),
        .fault_clr(faultClr), .periph_rd(unusedPrd1), .periph_wr(unusedPwr1),
        .periph_be(unusedPbe1), .periph_wdata(unusedPwdata1), .periph_rdata(periphRdata),
        .showaddr(showAddr), .ramshowdata(unusedRamShow1)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic        fclr;
        logic [31:0] expRead;
        logic        expPrd;
        logic        expPwr;
        logic [3:0]  expBe;
        logic [31:0] expPwdata;
        logic        expFault;
        logic [31:0] expFaultAddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pr,
                                input logic rd, input logic wr, input logic [1:0] sz,
                                input logic un, input logic fc, input logic [31:0] er,
                                input logic eprd, input logic epwr, input logic [3:0] ebe,
                                input logic [31:0] epwd, input logic ef, input logic [31:0] efa);
        vec_t v;
        v.addr = a; v.wdata = wd; v.prdata = pr; v.rd = rd; v.wr = wr; v.sz = sz;
        v.uns = un; v.fclr = fc; v.expRead = er; v.expPrd = eprd; v.expPwr = epwr;
        v.expBe = ebe; v.expPwdata = epwd; v.expFault = ef; v.expFaultAddr = efa;
        return v;
    endfunction

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        address     = v.addr;
        writeData   = v.wdata;
        periphRdata = v.prdata;
        memRead     = v.rd;
        memWrite    = v.wr;
        size        = v.sz;
        isUnsigned  = v.uns;
        faultClr    = v.fclr;
    endtask

    task automatic setIdle();
        address     = 32'h0;
        writeData   = 32'h0;
        periphRdata = 32'h0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        size        = 2'b10;
        isUnsigned  = 1'b0;
        faultClr    = 1'b0;
    endtask

    initial begin
        int cycles;
        int bad;
        localparam logic [31:0] PR = 32'hCAFEF00D;

        //            addr          wdata         prdata        rd wr sz    un fc expRead       prd pwr be       pwdata        f  faddr
        vecs.push_back(mk(32'h10,       32'h80FF7F01, PR,           0, 1, 2'b10, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h80FF7F01, 0, 32'h0));
        vecs.push_back(mk(32'h11,       32'h0,        PR,           1, 0, 2'b00, 0, 0, 32'h0000007F, 0, 0, 4'b0000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(32'h13,       32'h0,        PR,           1, 0, 2'b00, 0, 0, 32'hFFFFFF80, 0, 0, 4'b0000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(32'h12,       32'h0,        PR,           1, 0, 2'b00, 1, 0, 32'h000000FF, 0, 0, 4'b0000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(32'h20,       32'h11223344, PR,           0, 1, 2'b10, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(32'h22,       32'h0000BEEF, PR,           0, 1, 2'b01, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(32'h20,       32'h0,        PR,           1, 0, 2'b10, 0, 0, 32'hBEEF3344, 0, 0, 4'b0000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(32'h22,       32'h0,        PR,           1, 0, 2'b01, 0, 0, 32'hFFFFBEEF, 0, 0, 4'b0000, 32'h0,        0, 32'h0));
        vecs.push_back(mk(32'h05,       32'h0,        PR,           1, 0, 2'b10, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h05));
        vecs.push_back(mk(32'h3000,     32'h12345678, PR,           0, 1, 2'b10, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h05));
        vecs.push_back(mk(32'h07,       32'h0,        PR,           1, 0, 2'b01, 0, 1, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h07));
        vecs.push_back(mk(32'h0,        32'h0,        PR,           0, 0, 2'b10, 0, 1, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h07));
        vecs.push_back(mk(32'h40000002, 32'h000000A5, PR,           0, 1, 2'b00, 0, 0, 32'h0,        0, 1, 4'b0100, 32'hA5A5A5A5, 0, 32'h07));
        vecs.push_back(mk(32'h40000000, 32'h0,        32'h00008000, 1, 0, 2'b01, 1, 0, 32'h00008000, 1, 0, 4'b0011, 32'h0,        0, 32'h07));
        vecs.push_back(mk(32'h40000000, 32'h0,        32'h00008000, 1, 0, 2'b01, 0, 0, 32'hFFFF8000, 1, 0, 4'b0011, 32'h0,        0, 32'h07));
        vecs.push_back(mk(32'h0,        32'h0,        PR,           1, 0, 2'b10, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h07));
        vecs.push_back(mk(32'h40000003, 32'h0,        32'h80000000, 1, 0, 2'b00, 0, 0, 32'hFFFFFF80, 1, 0, 4'b1000, 32'h0,        0, 32'h07));
        vecs.push_back(mk(32'h23,       32'h0000005A, PR,           0, 1, 2'b00, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h07));
        vecs.push_back(mk(32'h20,       32'h0,        PR,           1, 0, 2'b10, 0, 0, 32'h5AEF3344, 0, 0, 4'b0000, 32'h0,        0, 32'h07));
        vecs.push_back(mk(32'h20,       32'h0,        PR,           0, 0, 2'b10, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        0, 32'h07));
        vecs.push_back(mk(32'h24,       32'h0,        PR,           1, 0, 2'b11, 0, 0, 32'h0,        0, 0, 4'b0000, 32'h0,        1, 32'h24));

        // Reset state while reset is held.
        setIdle();
        showAddr = '0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'h0, busy0}, 32'h1);
        checkOutput("reset fault", {31'h0, fault0}, 32'h0);
        checkOutput("reset fault_addr", faultAddr0, 32'h0);
        checkOutput("reset Read_data L1", readData1, 32'h0);

        // Clear restarts from index 0 when reset arrives mid-sequence.
        reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        checkOutput("mid-clear reset busy", {31'h0, busy1}, 32'h1);
        address  = 32'h40000000;
        size     = 2'b10;
        memRead  = 1'b1;
        memWrite = 1'b1;
        writeData = 32'hDEADBEEF;
        reset = 1'b0;

        // Accesses during the clear must be ignored: peripheral, illegal size, then a RAM store.
        cycles = 0;
        while (busy0 && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 64) begin
                checkOutput("clear Read_data L0", readData0, 32'h0);
                checkOutput("clear Read_data L1", readData1, 32'h0);
                checkOutput("clear periph_wr", {31'h0, pwr0}, 32'h0);
                checkOutput("clear periph_rd", {31'h0, prd0}, 32'h0);
                address = 32'h0;
                size    = 2'b11;
            end else if (cycles == 96) begin
                size = 2'b10;
            end
        end
        checkOutput("busy cycles", cycles, 32'd128);
        setIdle();
        checkOutput("clear fault", {31'h0, fault0}, 32'h0);
        checkOutput("clear fault L1", {31'h0, fault1}, 32'h0);

        bad = 0;
        for (int i = 0; i < (1 << AB); i++) begin
            showAddr = i[AB-1:0];
            #1;
            if (ramShow0 !== 32'h0) bad++;
        end
        checkOutput("ram cleared words", bad, 32'd0);

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d Read_data", i), readData0, vecs[i].expRead);
            checkOutput($sformatf("v%0d periph_rd", i), {31'h0, prd0}, {31'h0, vecs[i].expPrd});
            checkOutput($sformatf("v%0d periph_wr", i), {31'h0, pwr0}, {31'h0, vecs[i].expPwr});
            checkOutput($sformatf("v%0d periph_be", i), {28'h0, pbe0}, {28'h0, vecs[i].expBe});
            if (vecs[i].expPwr) begin
                checkOutput($sformatf("v%0d periph_wdata", i), pwdata0, vecs[i].expPwdata);
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d fault", i), {31'h0, fault0}, {31'h0, vecs[i].expFault});
            checkOutput($sformatf("v%0d fault_addr", i), faultAddr0, vecs[i].expFaultAddr);
        end

        // Read-before-write in both latency modes.
        setIdle();
        address   = 32'h8;
        writeData = 32'h99;
        memWrite  = 1'b1;
        @(posedge clk);
        #1;
        writeData = 32'h55;
        memRead   = 1'b1;
        #1;
        checkOutput("rbw L0 same cycle", readData0, 32'h99);
        checkOutput("rbw L1 prior idle", readData1, 32'h0);
        @(posedge clk);
        #1;
        memWrite = 1'b0;
        #1;
        checkOutput("rbw L1 old word", readData1, 32'h99);
        checkOutput("rbw L0 new word", readData0, 32'h55);
        @(posedge clk);
        #1;
        setIdle();
        #1;
        checkOutput("rbw L1 new word", readData1, 32'h55);
        @(posedge clk);
        #1;
        checkOutput("L1 idle zero", readData1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised successor to the single-cycle data memory. Adds byte/halfword/word access with sign or zero extension, little-endian byte-lane writes, and a hardware RAM-clear sequence after reset that replaces per-word reset assignment. Also adds misalignment and out-of-range fault capture and selectable read latency. Sits between the pipeline MEM stage and the peripheral block; Address[30] selects the peripheral region.

Parameters:
ADDR_BITS, 7, word-index width; RAM depth = 2**ADDR_BITS words
READ_LATENCY, 0, 0 = combinational RAM read, 1 = registered read (one-cycle latency)
INIT_VALUE, 32'h00000000, value written to every word by the clear sequence

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
Address  in  32  byte address
Write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
MemRead  in  1  load request
MemWrite  in  1  store request
Size  in  2  00 byte, 01 half, 10 word, 11 illegal
Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
Read_data  out  32  extended load data
busy  out  1  clear sequence in progress
fault  out  1  sticky access fault
fault_addr  out  32  Address of first captured fault
fault_clr  in  1  clears fault
periph_rd  out  1  MemRead & peripheral region & no fault
periph_wr  out  1  MemWrite & peripheral region & no fault
periph_be  out  4  byte enables for peripheral access
periph_wdata  out  32  lane-replicated store data
periph_rdata  in  32  peripheral read data, word-aligned
showaddr  in  ADDR_BITS  debug word index
ramshowdata  out  32  RAM[showaddr], combinational, always valid

Behaviour:
- Reset (async): state=CLEAR, clear counter=0, busy=1, fault=0, fault_addr=0, registered read data=0. RAM contents are not reset directly.
- CLEAR: each cycle write INIT_VALUE to RAM[counter] and increment the counter. After writing index 2**ADDR_BITS-1, go to RUN. busy falls exactly 2**ADDR_BITS cycles after reset deasserts.
- During CLEAR: external stores ignored, Read_data=0, periph_rd/periph_wr=0, no faults recorded. Reset asserted mid-CLEAR restarts at counter 0.
- Region decode:
  - Address[30]=1 → peripheral.
  - Address[30]=0 and Address[29:ADDR_BITS+2]==0 → RAM.
  - Otherwise out-of-range.
- Fault conditions, evaluated only when MemRead|MemWrite in RUN: Size=11; half with Address[0]=1; word with Address[1:0]!=0; out-of-range.
- On a fault: access suppressed (no RAM write, periph strobes 0), Read_data=0. If fault=0, set fault and capture fault_addr. Later faults do not overwrite fault_addr until cleared.
- fault_clr clears fault next edge. fault_clr coincident with a new fault: new fault wins (fault stays 1, fault_addr = new Address).
- Byte enables:
  - byte → 1<<Address[1:0]
  - half → 0011 or 1100 by Address[1]
  - word → 1111
- Write data: byte replicated to all 4 lanes, half to both halves; only enabled lanes of the RAM word update.
- Load: select the lane by Address[1:0] from the RAM word or periph_rdata, then sign- or zero-extend per Unsigned. Word loads ignore Unsigned.
- MemRead=0 → Read_data=0 (READ_LATENCY=0), or registered 0 (READ_LATENCY=1).
- MemRead and MemWrite together on same RAM word: store commits at the edge. Read_data returns the pre-store word in both latency modes (read-before-write).
- READ_LATENCY=1: Read_data is the registered extended result of the request one cycle earlier; holds 0 when the previous cycle had no valid load.

Test Plan:
- Reset with ADDR_BITS=7 → busy=1 for exactly 128 cycles; store during CLEAR ignored; ramshowdata for all indices = 0 afterwards.
- Store word 0x80FF7F01 @0x10, load byte @0x11 signed → 0x0000007F; @0x13 signed → 0xFFFFFF80; @0x12 unsigned → 0x000000FF.
- Store half 0xBEEF @0x22 onto word 0x11223344 @0x20 → word reads 0xBEEF3344; load half @0x22 signed → 0xFFFFBEEF.
- Load word @0x05 → fault=1, fault_addr=0x05, Read_data=0. Next store @0x3000 (out-of-range) → fault_addr stays 0x05. fault_clr together with a load half @0x07 → fault=1, fault_addr=0x07.
- Peripheral store byte 0xA5 @0x40000002 → periph_wr=1, periph_be=0100, periph_wdata=0xA5A5A5A5, RAM unchanged. With periph_rdata=0x00008000, load half @0x40000000 unsigned → 0x00008000.
- READ_LATENCY=1: same-cycle store 0x55 / load @0x8 where old=0x99 → Read_data=0x99 one cycle later; a load in the following cycle returns 0x55.
